// File: rtl/udma_ctrl_seq_pkg.sv
// Shared register map, sequencer state encoding and status bit positions for the uDMA control block.
package udma_ctrl_seq_pkg;

    localparam logic [4:0] REG_CG           = 5'h00;
    localparam logic [4:0] REG_CFG_EVT0     = 5'h01;
    localparam logic [4:0] REG_RST          = 5'h02;
    localparam logic [4:0] REG_CFG_EVT1     = 5'h03;
    localparam logic [4:0] REG_L2_DEST      = 5'h04;
    localparam logic [4:0] REG_L2_SRC       = 5'h05;
    localparam logic [4:0] REG_RST_PULSE    = 5'h06;
    localparam logic [4:0] REG_EVT_STATUS   = 5'h07;
    localparam logic [4:0] REG_EVT_CNT_BASE = 5'h08;

    localparam int BUSY_BIT = 31;
    localparam int ERR_BIT  = 30;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_CG_ON,
        SEQ_ASSERT,
        SEQ_RELEASE
    } seq_state_t;

endpackage

// File: rtl/udma_rst_seq.sv
// Reset-pulse sequencer: clock on, RST_CYCLES of forced reset, one release cycle, then idle.
// Starts one cycle after the triggering write; a start while busy is dropped and flagged via err_set.
module udma_rst_seq
    import udma_ctrl_seq_pkg::*;
#(
    parameter int N_PERIPHS  = 6,
    parameter int RST_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [N_PERIPHS-1:0] start_mask,
    output logic                 busy,
    output logic                 err_set,
    output logic [N_PERIPHS-1:0] rst_mask,
    output logic [N_PERIPHS-1:0] cg_mask
);

    localparam int CW = $clog2(RST_CYCLES + 1);

    seq_state_t           state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [N_PERIPHS-1:0] mask, mask_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEQ_IDLE;
            cnt   <= '0;
            mask  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            mask  <= mask_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mask_nxt  = mask;
        busy      = (state != SEQ_IDLE);
        err_set   = start && (state != SEQ_IDLE);
        rst_mask  = '0;
        cg_mask   = '0;
        case (state)
            SEQ_IDLE: begin
                if (start && (|start_mask)) begin
                    state_nxt = SEQ_CG_ON;
                    mask_nxt  = start_mask;
                end
            end
            SEQ_CG_ON: begin
                cg_mask   = mask;
                state_nxt = SEQ_ASSERT;
                cnt_nxt   = CW'(RST_CYCLES);
            end
            SEQ_ASSERT: begin
                cg_mask  = mask;
                rst_mask = mask;
                cnt_nxt  = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nxt = SEQ_RELEASE;
                end
            end
            SEQ_RELEASE: begin
                cg_mask   = mask;
                state_nxt = SEQ_IDLE;
                mask_nxt  = '0;
            end
            default: state_nxt = SEQ_IDLE;
        endcase
    end

endmodule

// File: rtl/udma_ctrl_seq.sv
// uDMA control/config: clock-gate/reset levels, L2 prefixes, event comparators with sticky status and hit counters.
// Comparators are zero-latency; status/counters update the cycle after a hit; config port never stalls.
module udma_ctrl_seq
    import udma_ctrl_seq_pkg::*;
#(
    parameter int L2_AWIDTH_NOAL = 15,
    parameter int N_PERIPHS      = 6,
    parameter int N_EVT_CMP      = 4,
    parameter int RST_CYCLES     = 8,
    parameter int CNT_WIDTH      = 16,
    localparam int PW            = 32 - L2_AWIDTH_NOAL
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [31:0]          cfg_data_i,
    input  logic [4:0]           cfg_addr_i,
    input  logic                 cfg_valid_i,
    input  logic                 cfg_rwn_i,
    output logic [31:0]          cfg_data_o,
    output logic                 cfg_ready_o,
    output logic [N_PERIPHS-1:0] rst_value_o,
    output logic [N_PERIPHS-1:0] cg_value_o,
    output logic                 cg_core_o,
    input  logic                 event_valid_i,
    input  logic [7:0]           event_data_i,
    output logic                 event_ready_o,
    output logic [N_EVT_CMP-1:0] event_o,
    output logic [PW-1:0]        l2_dest_o,
    output logic [PW-1:0]        l2_src_o
);

    logic                 cfg_we;
    logic [N_PERIPHS-1:0] r_cg, r_rst;
    logic [7:0]           r_cmp [N_EVT_CMP];
    logic [PW-1:0]        r_dest, r_src;
    logic [N_EVT_CMP-1:0] r_status, status_clr;
    logic                 r_err;
    logic [CNT_WIDTH-1:0] r_cnt [N_EVT_CMP];
    logic                 seq_busy, seq_err_set;
    logic [N_PERIPHS-1:0] seq_rst_mask, seq_cg_mask;

    assign cfg_we     = cfg_valid_i && !cfg_rwn_i;
    assign status_clr = (cfg_we && cfg_addr_i == REG_EVT_STATUS) ? cfg_data_i[N_EVT_CMP-1:0] : '0;

    udma_rst_seq #(
        .N_PERIPHS  (N_PERIPHS),
        .RST_CYCLES (RST_CYCLES)
    ) u_rst_seq (
        .clk        (clk_i),
        .rst_n      (rstn_i),
        .start      (cfg_we && cfg_addr_i == REG_RST_PULSE),
        .start_mask (cfg_data_i[N_PERIPHS-1:0]),
        .busy       (seq_busy),
        .err_set    (seq_err_set),
        .rst_mask   (seq_rst_mask),
        .cg_mask    (seq_cg_mask)
    );

    always_comb begin
        for (int i = 0; i < N_EVT_CMP; i++) begin
            event_o[i] = event_valid_i && (event_data_i == r_cmp[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cg     <= '0;
            r_rst    <= '0;
            r_dest   <= '0;
            r_src    <= '0;
            r_status <= '0;
            r_err    <= 1'b0;
            for (int i = 0; i < N_EVT_CMP; i++) begin
                r_cmp[i] <= '0;
                r_cnt[i] <= '0;
            end
        end else begin
            if (cfg_we) begin
                case (cfg_addr_i)
                    REG_CG:      r_cg   <= cfg_data_i[N_PERIPHS-1:0];
                    REG_RST:     r_rst  <= cfg_data_i[N_PERIPHS-1:0];
                    REG_L2_DEST: r_dest <= cfg_data_i[PW-1:0];
                    REG_L2_SRC:  r_src  <= cfg_data_i[PW-1:0];
                    default: ;
                endcase
            end
            // A new hit in the same cycle as a W1C keeps the bit set.
            r_status <= (r_status & ~status_clr) | event_o;
            if (seq_err_set) begin
                r_err <= 1'b1;
            end else if (cfg_we && cfg_addr_i == REG_EVT_STATUS && cfg_data_i[ERR_BIT]) begin
                r_err <= 1'b0;
            end
            for (int i = 0; i < N_EVT_CMP; i++) begin
                if (cfg_we && cfg_addr_i == ((i < 4) ? REG_CFG_EVT0 : REG_CFG_EVT1)) begin
                    r_cmp[i] <= cfg_data_i[8*(i%4) +: 8];
                end
                if (cfg_we && cfg_addr_i == REG_EVT_CNT_BASE + 5'(i)) begin
                    r_cnt[i] <= event_o[i] ? CNT_WIDTH'(1) : '0;
                end else if (event_o[i] && r_cnt[i] != {CNT_WIDTH{1'b1}}) begin
                    r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        cfg_data_o = '0;
        case (cfg_addr_i)
            REG_CG:  cfg_data_o[N_PERIPHS-1:0] = r_cg;
            REG_RST: cfg_data_o[N_PERIPHS-1:0] = r_rst;
            REG_CFG_EVT0: begin
                for (int i = 0; i < N_EVT_CMP; i++) begin
                    if (i < 4) cfg_data_o[8*(i%4) +: 8] = r_cmp[i];
                end
            end
            REG_CFG_EVT1: begin
                for (int i = 0; i < N_EVT_CMP; i++) begin
                    if (i >= 4) cfg_data_o[8*(i%4) +: 8] = r_cmp[i];
                end
            end
            REG_L2_DEST: cfg_data_o[PW-1:0] = r_dest;
            REG_L2_SRC:  cfg_data_o[PW-1:0] = r_src;
            REG_RST_PULSE: begin
                cfg_data_o[N_PERIPHS-1:0] = seq_cg_mask;
                cfg_data_o[BUSY_BIT]      = seq_busy;
                cfg_data_o[ERR_BIT]       = r_err;
            end
            REG_EVT_STATUS: cfg_data_o[N_EVT_CMP-1:0] = r_status;
            default: begin
                for (int i = 0; i < N_EVT_CMP; i++) begin
                    if (cfg_addr_i == REG_EVT_CNT_BASE + 5'(i)) cfg_data_o[CNT_WIDTH-1:0] = r_cnt[i];
                end
            end
        endcase
    end

    assign rst_value_o   = r_rst | seq_rst_mask;
    assign cg_value_o    = r_cg | seq_cg_mask;
    assign cg_core_o     = |cg_value_o;
    assign cfg_ready_o   = 1'b1;
    assign event_ready_o = 1'b1;
    assign l2_dest_o     = r_dest;
    assign l2_src_o      = r_src;

endmodule

// File: doc/udma_ctrl_seq.md
Name: udma_ctrl_seq

Overview:
Second-generation uDMA control/config block. It holds per-peripheral clock-gate and reset levels, the L2 address prefixes, and event comparators, with the comparator count parametrised (1..8). It adds three things: a hardware reset-pulse sequencer with clock-gate forcing, sticky event status, and per-comparator saturating hit counters. It sits between the uDMA APB config bus and the peripheral channels.

Parameters:
L2_AWIDTH_NOAL, 15, L2 address width without alignment bits; prefix width PW = 32-L2_AWIDTH_NOAL
N_PERIPHS, 6, number of peripherals (1..32)
N_EVT_CMP, 4, number of event comparators (1..8)
RST_CYCLES, 8, reset-pulse assert length in cycles (>=1)
CNT_WIDTH, 16, hit-counter width (1..32)

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
cfg_data_i  in  32  write data
cfg_addr_i  in  5  word address
cfg_valid_i  in  1  access strobe
cfg_rwn_i  in  1  1=read, 0=write
cfg_data_o  out  32  read data
cfg_ready_o  out  1  always 1
rst_value_o  out  N_PERIPHS  peripheral reset (active high)
cg_value_o  out  N_PERIPHS  peripheral clock enable
cg_core_o  out  1  OR of cg_value_o
event_valid_i  in  1  incoming event strobe
event_data_i  in  8  event id
event_ready_o  out  1  always 1
event_o  out  N_EVT_CMP  comparator match
l2_dest_o  out  PW  L2 destination prefix
l2_src_o  out  PW  L2 source prefix

Behaviour:
- Reset: all registers and counters 0; sequencer IDLE; every output 0 except cfg_ready_o=1 and event_ready_o=1.
- Writes (cfg_valid_i & ~cfg_rwn_i) take effect on the next edge. Reads are combinational in the same cycle. Unmapped or absent fields read 0.
- Register map (word address):
  - 0x00 CG rw [N_PERIPHS-1:0].
  - 0x01 CFG_EVT0 rw, comparators 0..3, one byte each (comparator 0 in bits [7:0]).
  - 0x02 RST rw, static reset level.
  - 0x03 CFG_EVT1 rw, comparators 4..7.
  - 0x04 L2_DEST rw [PW-1:0].
  - 0x05 L2_SRC rw [PW-1:0].
  - 0x06 RST_PULSE. Write = start mask. Read = {busy[31], err[30], active mask[N_PERIPHS-1:0]}.
  - 0x07 EVT_STATUS. Sticky hit bits [N_EVT_CMP-1:0]; writing 1 clears the bit. Write bit 30 = 1 clears err.
  - 0x08+i EVT_CNT[i] ro, i<N_EVT_CMP. Any write clears it.
- event_o[i] = event_valid_i & (event_data_i == cmp[i]), combinational, zero latency.
- Sticky status and counter updates are registered: visible the cycle after the hit.
- Status set and W1C in the same cycle: set wins (bit stays 1).
- Counters increment by 1 per hit and saturate at all-ones (no wrap). Clear and hit in the same cycle: result 1.
- Reset-pulse sequencer (sub-module):
  - IDLE -> CG_ON when RST_PULSE is written with a nonzero mask; mask latched. A zero mask does nothing.
  - CG_ON, 1 cycle: clock enable forced on for the mask.
  - ASSERT, RST_CYCLES cycles: reset forced high and clock enable forced on for the mask.
  - RELEASE, 1 cycle: reset released, clock enable still forced.
  - RELEASE -> IDLE; mask cleared.
  - busy = (state != IDLE).
  - A write to RST_PULSE while busy is ignored and sets sticky err.
- Output combine:
  - rst_value_o = r_rst | seq_rst_mask.
  - cg_value_o = r_cg | seq_cg_mask.
  - cg_core_o = |cg_value_o.
- Writes to CG/RST during a sequence update the static registers normally; the forced bits still dominate by OR.
- Width rules: data bits above N_PERIPHS, PW or CNT_WIDTH are ignored on write and read 0. Comparator fields for i >= N_EVT_CMP are not implemented and read 0.
- Asynchronous reset mid-sequence returns to IDLE and drops all forced outputs immediately.

Decomposition:
- Package udma_ctrl_seq_pkg:
  - register address localparams (REG_CG..REG_EVT_CNT_BASE);
  - sequencer state enum {SEQ_IDLE, SEQ_CG_ON, SEQ_ASSERT, SEQ_RELEASE};
  - RST_PULSE status bit positions (BUSY_BIT=31, ERR_BIT=30).
- One sub-module, udma_rst_seq:
  - params N_PERIPHS, RST_CYCLES;
  - inputs start, start_mask;
  - outputs busy, err_set, rst_mask, cg_mask;
  - contains the FSM and the $clog2(RST_CYCLES+1) down-counter.
- Comparators, status and counters stay in the top level.

Test Plan:
1. After reset, read 0x00..0x0F -> all 0; cg_core_o=0; event_o=0.
2. Write CFG_EVT0=0x0403_0201 and CFG_EVT1=0x0000_0005 (N_EVT_CMP=8) -> event_data_i=0x03 with valid gives event_o=0x04 same cycle. Valid=0 gives event_o=0. Read CFG_EVT0 returns 0x04030201.
3. CG=0, write RST_PULSE=0x05, RST_CYCLES=8:
   - cg_value_o=0x05 for 10 cycles (1+8+1);
   - rst_value_o=0x05 for exactly cycles 2..9;
   - busy reads 1 throughout, then everything returns to 0.
   - A second write 0x02 mid-sequence -> ignored, err=1; clear via 0x07 bit30.
4. CNT_WIDTH=2, five hits on cmp0 -> EVT_CNT0 reads 3 (saturated). Write 0x08 in the same cycle as a hit -> reads 1.
5. Status bit0 set; W1C 0x1 coincident with a new hit -> bit0 stays 1. W1C without a hit -> 0.
6. Assert rstn_i=0 during ASSERT -> rst_value_o and cg_value_o drop to 0 asynchronously; after release, busy=0 and a new pulse works.
